axi_config_arb: RTL and testbench

//  Shares one register-side config port (rd/raddr/rdata/rvalid, wr/waddr/wdata/wstrb, as driven by axi_config)

---
 rtl/axi_config_arb_pkg.sv | 13 +
 rtl/axi_config_arb_if.sv | 38 +++
 rtl/axi_config_rr_arb.sv | 32 +++
 rtl/axi_config_arb.sv | 140 ++++++++++++++
 tb/tb_axi_config_arb.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_config_arb_pkg.sv
// Shared types for the config-port arbiter: FSM encoding and the default abort pattern.
package axi_config_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR       = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_DATA_DFLT = 32'hDEADBEEF;

endpackage

// File: rtl/axi_config_arb_if.sv
// Requester bundle plus register-file port of the config arbiter.
// slave = the arbiter's view; master = the surrounding requesters and register file.
interface axi_config_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
);
  logic [NUM_REQ-1:0]                 req_rd;
  logic [NUM_REQ-1:0]                 req_wr;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_raddr;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_waddr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0][STRB_WIDTH-1:0] req_wstrb;
  logic [NUM_REQ-1:0]                 req_gnt;
  logic [NUM_REQ-1:0]                 req_rvalid;
  logic                               req_rerr;
  logic [DATA_WIDTH-1:0]              req_rdata;

  logic                               rd;
  logic [ADDR_WIDTH-1:0]              raddr;
  logic [DATA_WIDTH-1:0]              rdata;
  logic                               rvalid;
  logic                               wr;
  logic [ADDR_WIDTH-1:0]              waddr;
  logic [DATA_WIDTH-1:0]              wdata;
  logic [STRB_WIDTH-1:0]              wstrb;

  modport slave (
    input  req_rd, req_wr, req_raddr, req_waddr, req_wdata, req_wstrb, rdata, rvalid,
    output req_gnt, req_rvalid, req_rerr, req_rdata, rd, raddr, wr, waddr, wdata, wstrb
  );

  modport master (
    output req_rd, req_wr, req_raddr, req_waddr, req_wdata, req_wstrb, rdata, rvalid,
    input  req_gnt, req_rvalid, req_rerr, req_rdata, rd, raddr, wr, waddr, wdata, wstrb
  );
endinterface

// File: rtl/axi_config_rr_arb.sv
// Round-robin picker: first asserted request at or after ptr, wrapping; one-hot grant plus index.
module axi_config_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_vld
);

  logic [IW:0] idx_w;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, ptr} + (IW+1)'(k);
      if (idx_w >= (IW+1)'(NUM_REQ)) idx_w = idx_w - (IW+1)'(NUM_REQ);
      if (en && !gnt_vld && req[IW'(idx_w)]) begin
        gnt[IW'(idx_w)] = 1'b1;
        gnt_idx         = IW'(idx_w);
        gnt_vld         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_config_arb.sv
// Shares one register-file config port among NUM_REQ requesters: round-robin,
// one access in flight, read responses routed back to the owner, reads aborted on timeout.
module axi_config_arb
  import axi_config_arb_pkg::*;
#(
  parameter int                    NUM_REQ      = 2,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    STRB_WIDTH   = DATA_WIDTH/8,
  parameter int                    RD_TIMEOUT   = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(TIMEOUT_DATA_DFLT)
) (
  input logic             clk,
  input logic             rst_n,
  axi_config_arb_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_TIMEOUT+1);

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic                  rerr_q, rerr_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_vld;

  axi_config_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_arb (
    .req     (bus.req_rd | bus.req_wr),
    .ptr     (ptr_q),
    .en      (state_q == ST_IDLE),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    rerr_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (arb_vld) begin
        ptr_d   = (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + IW'(1);
        owner_d = arb_idx;
        // A requester holding both intents is served its write first.
        if (bus.req_wr[arb_idx]) begin
          waddr_d = bus.req_waddr[arb_idx];
          wdata_d = bus.req_wdata[arb_idx];
          wstrb_d = bus.req_wstrb[arb_idx];
          state_d = ST_WR;
        end else begin
          raddr_d = bus.req_raddr[arb_idx];
          state_d = ST_RD_ISSUE;
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_RD_ISSUE: begin
        cnt_d = '0;
        if (bus.rvalid) begin
          rdata_d           = bus.rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d           = ST_IDLE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (bus.rvalid) begin
          rdata_d           = bus.rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d           = ST_IDLE;
        end else if (cnt_q == CW'(RD_TIMEOUT-1)) begin
          rdata_d           = TIMEOUT_DATA;
          rerr_d            = 1'b1;
          rvalid_d[owner_q] = 1'b1;
          state_d           = ST_IDLE;
        end else if (cnt_q != CW'(RD_TIMEOUT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_gnt    = arb_gnt;
    bus.req_rvalid = rvalid_q;
    bus.req_rerr   = rerr_q;
    bus.req_rdata  = rdata_q;
    bus.rd         = (state_q == ST_RD_ISSUE);
    bus.raddr      = raddr_q;
    bus.wr         = (state_q == ST_WR);
    bus.waddr      = waddr_q;
    bus.wdata      = wdata_q;
    bus.wstrb      = wstrb_q;
  end

endmodule

// File: tb/tb_axi_config_arb.sv
// Scoreboard bench for axi_config_arb: directed requester traffic queues expected
// grants/strobes/responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_axi_config_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_config_arb_if #(.NUM_REQ(2)) bus ();

  axi_config_arb #(.NUM_REQ(2), .RD_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  typedef struct { int idx; logic [31:0] d; logic e; int lat; } rsp_t;

  int          exp_gnt[$];
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  rsp_t        exp_rsp[$];

  int n_pass = 0, n_total = 0;
  int last_gnt_cyc = 0, rd_cyc = 0;
  int rf_delay = -1;
  logic [31:0] rf_data = '0;
  logic stray = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic int pending();
    return exp_gnt.size() + exp_wr.size() + exp_rd.size() + exp_rsp.size();
  endfunction

  // register file: answers a rd after rf_delay cycles (-1 = never), plus one-shot stray rvalid
  initial begin : regfile
    int cd;
    cd = -1;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    forever begin
      @(negedge clk);
      bus.rvalid = 1'b0;
      if (!rst_n) cd = -1;
      if (stray) begin
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hBAD0BAD0;
        stray      = 1'b0;
      end
      if (bus.rd && rf_delay >= 0) cd = rf_delay;
      if (cd == 0) begin
        bus.rvalid = 1'b1;
        bus.rdata  = rf_data;
        cd         = -1;
      end else if (cd > 0) cd--;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.req_gnt != '0) begin
        chk("gnt_onehot", 64'($onehot(bus.req_gnt)), 1);
        if (exp_gnt.size() == 0) chk("unexp_gnt", bus.req_gnt, 0);
        else chk("gnt", bus.req_gnt, 64'(1) << exp_gnt.pop_front());
        last_gnt_cyc = cyc;
      end
      if (bus.wr) begin
        chk("rd_wr_overlap", bus.rd, 0);
        chk("wr_lat", cyc, last_gnt_cyc + 1);
        if (exp_wr.size() == 0) chk("unexp_wr", bus.wr, 0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("waddr", bus.waddr, w.a);
          chk("wdata", bus.wdata, w.d);
          chk("wstrb", bus.wstrb, w.s);
        end
      end
      if (bus.rd) begin
        chk("rd_lat", cyc, last_gnt_cyc + 1);
        rd_cyc = cyc;
        if (exp_rd.size() == 0) chk("unexp_rd", bus.rd, 0);
        else chk("raddr", bus.raddr, exp_rd.pop_front());
      end
      if (bus.req_rvalid != '0) begin
        if (exp_rsp.size() == 0) chk("unexp_rvalid", bus.req_rvalid, 0);
        else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("rvalid_owner", bus.req_rvalid, 64'(1) << r.idx);
          chk("rdata", bus.req_rdata, r.d);
          chk("rerr", bus.req_rerr, r.e);
          chk("rsp_lat", cyc, rd_cyc + r.lat);
        end
      end
    end
  end

  task automatic wait_gnt(input int i);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_gnt[i] && n < 64);
    if (!bus.req_gnt[i]) chk($sformatf("gnt%0d_timeout", i), bus.req_gnt[i], 1);
    @(posedge clk); #1;
  endtask

  task automatic do_wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.req_waddr[i] = a;
    bus.req_wdata[i] = d;
    bus.req_wstrb[i] = s;
    bus.req_wr[i]    = 1'b1;
    wait_gnt(i);
    bus.req_wr[i]    = 1'b0;
  endtask

  task automatic do_rd(input int i, input logic [31:0] a);
    bus.req_raddr[i] = a;
    bus.req_rd[i]    = 1'b1;
    wait_gnt(i);
    bus.req_rd[i]    = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin @(posedge clk); n++; end
    if (pending() != 0) chk("drain_timeout", pending(), 0);
    @(posedge clk); #1;
  endtask

  task automatic push_wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_gnt.push_back(i);
    exp_wr.push_back('{a: a, d: d, s: s});
  endtask

  initial begin : stim
    rst_n = 1'b0;
    bus.req_rd = '0; bus.req_wr = '0;
    bus.req_raddr = '0; bus.req_waddr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    #3;
    chk("rst_gnt", bus.req_gnt, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_wr", bus.wr, 0);
    chk("rst_rvalid", bus.req_rvalid, 0);
    chk("rst_rdata", bus.req_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single write from requester 0
    push_wr(0, 32'h10, 32'hA5A5A5A5, 4'hF);
    do_wr(0, 32'h10, 32'hA5A5A5A5, 4'hF);
    drain(20);

    // 2: requester 1 read answered 3 cycles after rd
    rf_delay = 3; rf_data = 32'h1234;
    exp_gnt.push_back(1); exp_rd.push_back(32'h20);
    exp_rsp.push_back('{idx: 1, d: 32'h1234, e: 1'b0, lat: 4});
    do_rd(1, 32'h20);
    drain(30);

    // 3: both requesters hold writes continuously -> 0,1,0,1
    push_wr(0, 32'h100, 32'h11111111, 4'hF);
    push_wr(1, 32'h200, 32'h22222222, 4'h3);
    push_wr(0, 32'h104, 32'h33333333, 4'hC);
    push_wr(1, 32'h204, 32'h44444444, 4'h1);
    fork
      begin do_wr(0, 32'h100, 32'h11111111, 4'hF); do_wr(0, 32'h104, 32'h33333333, 4'hC); end
      begin do_wr(1, 32'h200, 32'h22222222, 4'h3); do_wr(1, 32'h204, 32'h44444444, 4'h1); end
    join
    drain(30);

    // 4: read never answered -> abort after RD_TIMEOUT, then a stray rvalid must be dropped
    rf_delay = -1;
    exp_gnt.push_back(0); exp_rd.push_back(32'h30);
    exp_rsp.push_back('{idx: 0, d: 32'hDEADBEEF, e: 1'b1, lat: 9});
    do_rd(0, 32'h30);
    drain(40);
    stray = 1'b1;
    repeat (4) @(posedge clk); #1;

    // 5: requester 0 holds rd+wr: write first, then the read on re-arbitration
    rf_delay = 0; rf_data = 32'h55AA;
    push_wr(0, 32'h50, 32'hCAFEF00D, 4'h6);
    exp_gnt.push_back(0); exp_rd.push_back(32'h54);
    exp_rsp.push_back('{idx: 0, d: 32'h55AA, e: 1'b0, lat: 1});
    bus.req_raddr[0] = 32'h54;
    bus.req_waddr[0] = 32'h50; bus.req_wdata[0] = 32'hCAFEF00D; bus.req_wstrb[0] = 4'h6;
    bus.req_rd[0] = 1'b1; bus.req_wr[0] = 1'b1;
    wait_gnt(0);
    bus.req_wr[0] = 1'b0;
    wait_gnt(0);
    bus.req_rd[0] = 1'b0;
    drain(20);

    // 6: reset while waiting on a read
    rf_delay = -1;
    exp_gnt.push_back(0); exp_rd.push_back(32'h40);
    do_rd(0, 32'h40);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_raddr", bus.raddr, 0);
    chk("mid_rst_rdata", bus.req_rdata, 0);
    chk("mid_rst_rd", bus.rd, 0);
    chk("mid_rst_rvalid", bus.req_rvalid, 0);
    chk("mid_rst_waddr", bus.waddr, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;

    // 7: pointer back at 0 after reset -> requester 0 wins first
    push_wr(0, 32'h60, 32'h01020304, 4'hF);
    push_wr(1, 32'h70, 32'h05060708, 4'hF);
    fork
      do_wr(0, 32'h60, 32'h01020304, 4'hF);
      do_wr(1, 32'h70, 32'h05060708, 4'hF);
    join
    drain(20);

    chk("queues_empty", pending(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
